// File: rtl/inst_encode_queue_pkg.sv
// Shared opcode constants, command classes and RV32I/A field packers used by
// the instruction encode queue (values match the decoder's case items).
package inst_encode_queue_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_AMO    = 7'b0101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] BUBBLE_INST = 32'h0000_0000;

    typedef enum logic [3:0] {
        CLS_R      = 4'd0,
        CLS_I_ALU  = 4'd1,
        CLS_LOAD   = 4'd2,
        CLS_STORE  = 4'd3,
        CLS_BRANCH = 4'd4,
        CLS_JAL    = 4'd5,
        CLS_JALR   = 4'd6,
        CLS_LUI    = 4'd7,
        CLS_AUIPC  = 4'd8,
        CLS_SYSTEM = 4'd9,
        CLS_AMO    = 4'd10
    } cmd_class_e;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [6:0] op);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
    endfunction

    // imm_12_1 is the byte offset with bit 0 already dropped
    function automatic logic [31:0] enc_b(input logic [11:0] imm_12_1, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [6:0] op);
        return {imm_12_1[11], imm_12_1[9:4], rs2, rs1, f3, imm_12_1[3:0], imm_12_1[10], op};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm_31_12, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm_31_12, rd, op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [19:0] imm_20_1, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm_20_1[19], imm_20_1[9:0], imm_20_1[10], imm_20_1[18:11], rd, op};
    endfunction

endpackage

// File: rtl/inst_encode_queue_if.sv
// Command and instruction-issue handshake bundle between a sequencer (master)
// and the encode queue (slave).
interface inst_encode_queue_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_class;
    logic [4:0]       cmd_rd;
    logic [4:0]       cmd_rs1;
    logic [4:0]       cmd_rs2;
    logic [2:0]       cmd_funct3;
    logic             cmd_alt;
    logic [31:0]      cmd_imm;
    logic             inst_valid;
    logic             inst_ready;
    logic [31:0]      inst;
    logic             enc_err;
    logic [CNT_W-1:0] count;

    modport master (
        output cmd_valid, cmd_class, cmd_rd, cmd_rs1, cmd_rs2, cmd_funct3, cmd_alt, cmd_imm,
        output inst_ready,
        input  cmd_ready, inst_valid, inst, enc_err, count
    );

    modport slave (
        input  cmd_valid, cmd_class, cmd_rd, cmd_rs1, cmd_rs2, cmd_funct3, cmd_alt, cmd_imm,
        input  inst_ready,
        output cmd_ready, inst_valid, inst, enc_err, count
    );
endinterface

// File: rtl/inst_encode_queue_sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous clear.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_en_s;
    logic             pop_en_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign push_en_s = push & ~full;
    assign pop_en_s  = pop & ~empty;

    // Storage, pointers (wrap naturally at power-of-2 DEPTH) and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (clr) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_en_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_en_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_en_s, pop_en_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/inst_encode_queue.sv
// Encodes field-level commands into RV32I/A words, queues them and issues them
// to decode; a flush drops queued work and presents one all-zero bubble.
module inst_encode_queue
    import inst_encode_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    inst_encode_queue_if.slave bus
);
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]       state_r;
    logic [0:0]       state_nxt_s;
    logic             enc_err_r;
    logic [31:0]      enc_word_s;
    logic             enc_legal_s;
    logic [11:0]      ialu_imm_s;
    logic             cmd_ready_s;
    logic             accept_s;
    logic             push_s;
    logic             pop_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic [31:0]      head_s;

    // Shift-immediate forms carry alt in bit 30 and a 5-bit shamt
    always_comb begin
        ialu_imm_s = bus.cmd_imm[11:0];
        if (bus.cmd_funct3 == 3'b001 || bus.cmd_funct3 == 3'b101) begin
            ialu_imm_s = {1'b0, bus.cmd_alt, 5'b00000, bus.cmd_imm[4:0]};
        end else begin
            ialu_imm_s = bus.cmd_imm[11:0];
        end
    end

    // Combinational encoder from command fields
    always_comb begin
        enc_word_s  = BUBBLE_INST;
        enc_legal_s = 1'b1;
        case (cmd_class_e'(bus.cmd_class))
            CLS_R:      enc_word_s = enc_r({1'b0, bus.cmd_alt, 5'b00000}, bus.cmd_rs2, bus.cmd_rs1,
                                           bus.cmd_funct3, bus.cmd_rd, OP_OP);
            CLS_I_ALU:  enc_word_s = enc_i(ialu_imm_s, bus.cmd_rs1, bus.cmd_funct3, bus.cmd_rd, OP_IMM);
            CLS_LOAD:   enc_word_s = enc_i(bus.cmd_imm[11:0], bus.cmd_rs1, bus.cmd_funct3, bus.cmd_rd, OP_LOAD);
            CLS_STORE:  enc_word_s = enc_s(bus.cmd_imm[11:0], bus.cmd_rs2, bus.cmd_rs1, bus.cmd_funct3, OP_STORE);
            CLS_BRANCH: enc_word_s = enc_b(bus.cmd_imm[12:1], bus.cmd_rs2, bus.cmd_rs1, bus.cmd_funct3, OP_BRANCH);
            CLS_JAL:    enc_word_s = enc_j(bus.cmd_imm[20:1], bus.cmd_rd, OP_JAL);
            CLS_JALR:   enc_word_s = enc_i(bus.cmd_imm[11:0], bus.cmd_rs1, bus.cmd_funct3, bus.cmd_rd, OP_JALR);
            CLS_LUI:    enc_word_s = enc_u(bus.cmd_imm[31:12], bus.cmd_rd, OP_LUI);
            CLS_AUIPC:  enc_word_s = enc_u(bus.cmd_imm[31:12], bus.cmd_rd, OP_AUIPC);
            CLS_SYSTEM: enc_word_s = enc_i(bus.cmd_imm[11:0], bus.cmd_rs1, bus.cmd_funct3, bus.cmd_rd, OP_SYSTEM);
            CLS_AMO:    enc_word_s = enc_r(bus.cmd_imm[6:0], bus.cmd_rs2, bus.cmd_rs1,
                                           bus.cmd_funct3, bus.cmd_rd, OP_AMO);
            default: begin
                enc_word_s  = BUBBLE_INST;
                enc_legal_s = 1'b0;
            end
        endcase
    end

    // A flush in the same cycle blocks the command even though ready is high
    assign cmd_ready_s = (state_r == ST_RUN) & ~fifo_full_s;
    assign accept_s    = bus.cmd_valid & cmd_ready_s & ~flush;
    assign push_s      = accept_s & enc_legal_s;
    assign pop_s       = (state_r == ST_RUN) & bus.inst_ready & ~fifo_empty_s & ~flush;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset_n),
        .clr   (flush),
        .push  (push_s),
        .wdata (enc_word_s),
        .pop   (pop_s),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Next-state: flush wins; the bubble retires when decode takes it
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (flush) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (flush) begin
                    state_nxt_s = ST_FLUSH;
                end else if (bus.inst_ready) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // State and the illegal-class pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_RUN;
            enc_err_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            enc_err_r <= accept_s & ~enc_legal_s;
        end
    end

    assign bus.cmd_ready  = cmd_ready_s;
    assign bus.inst_valid = (state_r == ST_FLUSH) | ~fifo_empty_s;
    assign bus.inst       = ((state_r == ST_FLUSH) || fifo_empty_s) ? BUBBLE_INST : head_s;
    assign bus.enc_err    = enc_err_r;
    assign bus.count      = fifo_count_s;
endmodule

// File: tb/tb_inst_encode_queue.sv
// Self-checking bench: directed literal cases plus randomized traffic against a
// queue-based reference model of the encode queue.
module tb_inst_encode_queue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic flush = 1'b0;
    int   errors = 0;
    int   checks = 0;
    bit   run_chk = 1'b0;

    inst_encode_queue_if #(.DEPTH(DEPTH)) bus ();

    inst_encode_queue #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_q[$];
    bit          m_flush = 1'b0;
    bit          m_err = 1'b0;

    function automatic logic [31:0] m_enc(input int cls, input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                                          input logic [31:0] imm, output bit legal);
        logic [31:0] w, rdf, f3f, r1f, r2f, iv;
        rdf = 32'(rd) << 7; f3f = 32'(f3) << 12; r1f = 32'(rs1) << 15; r2f = 32'(rs2) << 20;
        legal = 1'b1;
        case (cls)
            0:  w = 32'h33 | rdf | f3f | r1f | r2f | (32'(alt) << 30);
            1:  begin
                    if (f3 == 3'd1 || f3 == 3'd5) iv = (imm % 32'd32) + 32'(alt) * 32'd1024;
                    else iv = imm & 32'hFFF;
                    w = 32'h13 | rdf | f3f | r1f | (iv << 20);
                end
            2:  w = 32'h03 | rdf | f3f | r1f | ((imm & 32'hFFF) << 20);
            3:  w = 32'h23 | ((imm & 32'd31) << 7) | f3f | r1f | r2f | (((imm >> 5) & 32'd127) << 25);
            4:  w = 32'h63 | (((imm >> 11) & 32'd1) << 7) | (((imm >> 1) & 32'd15) << 8) | f3f | r1f | r2f
                    | (((imm >> 5) & 32'd63) << 25) | (((imm >> 12) & 32'd1) << 31);
            5:  w = 32'h6F | rdf | (((imm >> 12) & 32'd255) << 12) | (((imm >> 11) & 32'd1) << 20)
                    | (((imm >> 1) & 32'd1023) << 21) | (((imm >> 20) & 32'd1) << 31);
            6:  w = 32'h67 | rdf | f3f | r1f | ((imm & 32'hFFF) << 20);
            7:  w = 32'h37 | rdf | (imm & 32'hFFFF_F000);
            8:  w = 32'h17 | rdf | (imm & 32'hFFFF_F000);
            9:  w = 32'h73 | rdf | f3f | r1f | ((imm & 32'hFFF) << 20);
            10: w = 32'h2F | rdf | f3f | r1f | r2f | ((imm & 32'd127) << 25);
            default: begin w = 32'h0; legal = 1'b0; end
        endcase
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each active edge, or immediately on reset
    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_q.delete(); m_flush = 1'b0; m_err = 1'b0;
            end else if (flush) begin
                m_q.delete(); m_flush = 1'b1; m_err = 1'b0;
            end else if (m_flush) begin
                if (bus.inst_ready) m_flush = 1'b0;
                m_err = 1'b0;
            end else begin
                bit rdy, legal;
                logic [31:0] w;
                rdy = (m_q.size() < DEPTH);
                m_err = 1'b0;
                if (bus.inst_ready && m_q.size() > 0) void'(m_q.pop_front());
                if (bus.cmd_valid && rdy) begin
                    w = m_enc(int'(bus.cmd_class), bus.cmd_rd, bus.cmd_rs1, bus.cmd_rs2,
                              bus.cmd_funct3, bus.cmd_alt, bus.cmd_imm, legal);
                    if (legal) m_q.push_back(w);
                    else m_err = 1'b1;
                end
            end
        end
    end

    // Compare DUT outputs against the model on every falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (run_chk) begin
                check("inst_valid", 32'(bus.inst_valid), 32'(m_flush || m_q.size() > 0));
                check("inst", bus.inst, (!m_flush && m_q.size() > 0) ? m_q[0] : 32'h0);
                check("cmd_ready", 32'(bus.cmd_ready), 32'(!m_flush && m_q.size() < DEPTH));
                check("count", 32'(bus.count), 32'(m_q.size()));
                check("enc_err", 32'(bus.enc_err), 32'(m_err));
            end
        end
    end

    task automatic send(input logic [3:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                        input logic [31:0] imm);
        int n;
        bus.cmd_class = cls; bus.cmd_rd = rd; bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2;
        bus.cmd_funct3 = f3; bus.cmd_alt = alt; bus.cmd_imm = imm; bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL send_timeout actual=cmd_ready_low required=accept_within_50");
        end else begin
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        bit lg;
        bus.cmd_valid = 1'b0; bus.cmd_class = 4'd0; bus.cmd_rd = 5'd0; bus.cmd_rs1 = 5'd0;
        bus.cmd_rs2 = 5'd0; bus.cmd_funct3 = 3'd0; bus.cmd_alt = 1'b0; bus.cmd_imm = 32'd0;
        bus.inst_ready = 1'b0;

        // Pin the model to hand-computed words
        check("model_r", m_enc(0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, lg), 32'h002081B3);
        check("model_sub", m_enc(0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0, lg), 32'h402081B3);
        check("model_branch", m_enc(4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFF_FFFC, lg), 32'hFE208EE3);
        check("model_jal", m_enc(5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8, lg), 32'h008000EF);

        #12;
        check("reset_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("reset_inst", bus.inst, 32'd0);
        check("reset_count", 32'(bus.count), 32'd0);
        check("reset_enc_err", 32'(bus.enc_err), 32'd0);
        check("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk); #2; reset_n = 1'b1; run_chk = 1'b1;
        tick(1);

        bus.inst_ready = 1'b1;
        send(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0);
        check("r_valid", 32'(bus.inst_valid), 32'd1);
        check("r_inst", bus.inst, 32'h002081B3);
        send(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0);
        check("sub_inst", bus.inst, 32'h402081B3);
        send(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFF_FFFF);
        check("addi_inst", bus.inst, 32'hFFF00093);
        send(4'd7, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5000);
        check("lui_inst", bus.inst, 32'h123452B7);
        send(4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8);
        check("jal_inst", bus.inst, 32'h008000EF);
        send(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFF_FFFC);
        check("branch_inst", bus.inst, 32'hFE208EE3);
        tick(2);

        // Fill to DEPTH with decode stalled, then drain
        bus.inst_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send(4'd2, 5'(i + 1), 5'd2, 5'd0, 3'd2, 1'b0, 32'(4 * i));
        check("full_count", 32'(bus.count), 32'(DEPTH));
        check("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("full_head", bus.inst, 32'h0001_2083);
        bus.inst_ready = 1'b1;
        tick(1);
        check("drain_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("drain_count", 32'(bus.count), 32'(DEPTH - 1));
        check("drain_head", bus.inst, 32'h0041_2103);
        tick(DEPTH);

        // Flush with three entries queued and a concurrent command
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(4'd9, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'(i));
        flush = 1'b1;
        bus.cmd_class = 4'd0; bus.cmd_valid = 1'b1;
        tick(1);
        flush = 1'b0; bus.cmd_valid = 1'b0;
        check("flush_count", 32'(bus.count), 32'd0);
        check("flush_valid", 32'(bus.inst_valid), 32'd1);
        check("flush_inst", bus.inst, 32'h0);
        check("flush_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        tick(2);
        check("flush_hold", 32'(bus.inst_valid), 32'd1);
        bus.inst_ready = 1'b1;
        tick(1);
        check("flush_done_valid", 32'(bus.inst_valid), 32'd0);
        check("flush_done_ready", 32'(bus.cmd_ready), 32'd1);

        // Illegal class
        send(4'd13, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'd0);
        check("illegal_err", 32'(bus.enc_err), 32'd1);
        check("illegal_count", 32'(bus.count), 32'd0);
        tick(1);
        check("illegal_err_pulse", 32'(bus.enc_err), 32'd0);

        // Reset mid-queue
        bus.inst_ready = 1'b0;
        send(4'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd16);
        send(4'd8, 5'd4, 5'd0, 5'd0, 3'd0, 1'b0, 32'hABCD_E000);
        #1 reset_n = 1'b0;
        #1;
        check("rst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_inst", bus.inst, 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        @(posedge clk); #2; reset_n = 1'b1;
        tick(1);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = int'($urandom_range(0, 19));
            bus.cmd_valid  = 1'($urandom_range(0, 1));
            bus.cmd_class  = (r <= 15) ? 4'(r) : 4'(r % 11);
            bus.cmd_rd     = 5'($urandom); bus.cmd_rs1 = 5'($urandom); bus.cmd_rs2 = 5'($urandom);
            bus.cmd_funct3 = 3'($urandom); bus.cmd_alt = 1'($urandom);
            bus.cmd_imm    = $urandom;
            bus.inst_ready = ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            flush          = ($urandom_range(0, 39) == 0);
            tick(1);
        end
        bus.cmd_valid = 1'b0; flush = 1'b0; bus.inst_ready = 1'b1;
        tick(8);
        run_chk = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
